// File: rtl/tcp_pkg.sv
// Shared types for the TCP transmit path.
//
// Holds the flow-state, four-tuple, header, payload-descriptor and
// scheduler-command layouts, plus the segment-calculation bundle passed
// from the CALC stage to the OUT stage of tcp_tx_seg_builder.

`ifndef IP_ADDR_W
`define IP_ADDR_W 32
`endif

package tcp_pkg;

    localparam int FLOWID_W         = 6;
    localparam int TX_PAYLOAD_PTR_W = 15;
    // The TX buffer pointer carries one extra wrap bit.
    localparam int PTR_W            = TX_PAYLOAD_PTR_W + 1;
    localparam int LEN_W            = 16;
    localparam int IP_ADDR_W        = `IP_ADDR_W;

    localparam int unsigned MSS_DEFAULT = 1460;

    localparam logic [7:0] TCP_FLAG_ACK  = 8'h10;
    localparam logic [7:0] TCP_FLAG_PSH  = 8'h08;
    // A header with no options is five 32-bit words.
    localparam logic [3:0] TCP_HDR_WORDS = 4'd5;

    typedef enum logic [1:0] {
        SCHED_NOP   = 2'd0,
        SCHED_SET   = 2'd1,
        SCHED_CLEAR = 2'd2
    } sched_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_CALC,
        ST_OUT
    } seg_state_e;

    typedef struct packed {
        logic [31:0] ack_num;
    } ack_state_struct;

    typedef struct packed {
        logic [31:0] our_seq_num;
    } smol_tx_state_struct;

    typedef struct packed {
        ack_state_struct our_ack_state;
        logic [31:0]     their_ack_num;
        logic [15:0]     our_win_size;
        logic [15:0]     their_win_size;
    } smol_rx_state_struct;

    typedef struct packed {
        logic [IP_ADDR_W-1:0] host_ip;
        logic [IP_ADDR_W-1:0] dest_ip;
        logic [15:0]          host_port;
        logic [15:0]          dest_port;
    } four_tuple_struct;

    typedef struct packed {
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [31:0] seq_num;
        logic [31:0] ack_num;
        logic [3:0]  data_offset;
        logic [3:0]  reserved;
        logic [7:0]  flags;
        logic [15:0] win_size;
        logic [15:0] chksum;
        logic [15:0] urg_ptr;
    } tcp_pkt_hdr;

    typedef struct packed {
        logic [PTR_W-1:0] payload_addr;
        logic [LEN_W-1:0] payload_len;
    } payload_buf_struct;

    typedef struct packed {
        logic [FLOWID_W-1:0] flowid;
        sched_op_e           rt_pend;
        sched_op_e           ack_pend;
        sched_op_e           data_pend;
    } sched_cmd_struct;

    typedef struct packed {
        logic [31:0]      seq;
        logic [LEN_W-1:0] len;
        logic [PTR_W-1:0] avail;
    } seg_calc_struct;

    // Returns whichever of cur/cand lies further forward in 32-bit
    // sequence space, so a retransmit never pulls the send pointer back.
    function automatic logic [31:0] seq_max_fwd(input logic [31:0] cur,
                                                input logic [31:0] cand);
        logic signed [31:0] diff;
        diff = cand - cur;
        return (diff > 0) ? cand : cur;
    endfunction

endpackage

// File: rtl/tcp_hdr_assembler.sv
// Packs the per-segment fields into a TCP header with no options.
//
// Ports:
//   src_port, dst_port  - flow ports
//   seq_num, ack_num    - sequence / acknowledgement numbers
//   flags               - TCP flag byte
//   win_size            - advertised receive window
//   hdr                 - assembled header (checksum left to a later stage)

module tcp_hdr_assembler
    import tcp_pkg::*;
(
    input  logic [15:0] src_port,
    input  logic [15:0] dst_port,
    input  logic [31:0] seq_num,
    input  logic [31:0] ack_num,
    input  logic [7:0]  flags,
    input  logic [15:0] win_size,
    output tcp_pkt_hdr  hdr
);

    always_comb begin
        hdr             = '0;
        hdr.src_port    = src_port;
        hdr.dst_port    = dst_port;
        hdr.seq_num     = seq_num;
        hdr.ack_num     = ack_num;
        hdr.data_offset = TCP_HDR_WORDS;
        hdr.flags       = flags;
        hdr.win_size    = win_size;
    end

endmodule

// File: rtl/tcp_tx_len_calc.sv
// Combinational payload-length computation for one segment.
//
// Ports:
//   seq        - first sequence number to send
//   ackd       - highest sequence number acknowledged by the peer
//   tail       - TX buffer tail pointer (with wrap bit)
//   their_win  - peer's advertised window
//   len        - bytes to put in this segment: min(avail, usable, MSS)
//   avail      - bytes queued in the TX buffer from seq up to tail

module tcp_tx_len_calc
    import tcp_pkg::*;
#(
    parameter int unsigned MSS = MSS_DEFAULT
) (
    input  logic [31:0]      seq,
    input  logic [31:0]      ackd,
    input  logic [PTR_W-1:0] tail,
    input  logic [15:0]      their_win,
    output logic [LEN_W-1:0] len,
    output logic [PTR_W-1:0] avail
);

    logic [31:0] inflight;
    logic [31:0] win_ext;
    logic [31:0] usable;
    logic [31:0] avail_ext;
    logic [31:0] min_au;
    logic [31:0] len_ext;

    always_comb begin
        inflight  = seq - ackd;
        win_ext   = {16'd0, their_win};
        usable    = (win_ext > inflight) ? (win_ext - inflight) : 32'd0;
        // Pointer subtraction wraps over the pointer width, so a tail that
        // is numerically below seq still yields the right byte count.
        avail     = tail - seq[PTR_W-1:0];
        avail_ext = 32'(avail);
        min_au    = (avail_ext < usable) ? avail_ext : usable;
        len_ext   = (min_au < 32'(MSS)) ? min_au : 32'(MSS);
        len       = LEN_W'(len_ext);
    end

endmodule

// File: rtl/tcp_tx_seg_builder.sv
// Transmit-side segment builder.
//
// Accepts one service command at a time from the scheduler, reads the
// flow's TX state, RX state, TX tail pointer and four-tuple, computes the
// segment (seq, len, window), and emits one header + payload descriptor.
// On the segment handshake it writes back the advanced our_seq_num and
// sends the scheduler an update clearing the serviced pend bits.
//
// Ports:
//   clk, rst                  - clock, asynchronous active-low reset
//   sched_tx_*                - service command (val/rdy, flowid, rt, ack)
//   *_rd_req_addr / *_rd_resp - 1-cycle synchronous state memory reads
//   tx_state_wr_req_*         - our_seq_num writeback (single-cycle pulse)
//   seg_out_*                 - outbound header + payload descriptor
//   sched_update_*            - pend-bit update to the scheduler

module tcp_tx_seg_builder
    import tcp_pkg::*;
#(
    parameter int unsigned MSS = MSS_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     sched_tx_val,
    output logic                     sched_tx_rdy,
    input  logic [FLOWID_W-1:0]      sched_tx_flowid,
    input  logic                     sched_tx_rt,
    input  logic                     sched_tx_ack,

    output logic [FLOWID_W-1:0]      tx_state_rd_req_addr,
    input  smol_tx_state_struct      tx_state_rd_resp_data,
    output logic [FLOWID_W-1:0]      rx_state_rd_req_addr,
    input  smol_rx_state_struct      rx_state_rd_resp_data,
    output logic [FLOWID_W-1:0]      tx_tail_ptr_rd_req_addr,
    input  logic [PTR_W-1:0]         tx_tail_ptr_rd_resp_data,
    output logic [FLOWID_W-1:0]      flow_tuple_rd_req_addr,
    input  four_tuple_struct         flow_tuple_rd_resp_data,

    output logic                     tx_state_wr_req_val,
    output logic [FLOWID_W-1:0]      tx_state_wr_req_addr,
    output smol_tx_state_struct      tx_state_wr_req_data,

    output logic                     seg_out_val,
    input  logic                     seg_out_rdy,
    output tcp_pkt_hdr               seg_out_hdr,
    output logic [FLOWID_W-1:0]      seg_out_flowid,
    output logic [`IP_ADDR_W-1:0]    seg_out_src_ip,
    output logic [`IP_ADDR_W-1:0]    seg_out_dst_ip,
    output payload_buf_struct        seg_out_payload,

    output logic                     sched_update_val,
    output sched_cmd_struct          sched_update_cmd
);

    seg_state_e          state_q, state_d;

    logic [FLOWID_W-1:0] flowid_q;
    logic                rt_q;
    logic                ack_q;
    seg_calc_struct      calc_q;
    logic [31:0]         their_ack_q;
    logic [15:0]         our_win_q;
    four_tuple_struct    tuple_q;
    logic [31:0]         tx_seq_q;
    logic                skip_pulse_q;

    logic                cmd_accept;
    logic                skip;
    logic                seg_fire;

    logic [31:0]         calc_seq;
    logic [LEN_W-1:0]    calc_len;
    logic [PTR_W-1:0]    calc_avail;
    logic [7:0]          hdr_flags;
    tcp_pkt_hdr          hdr;
    logic [31:0]         next_seq;

    // ------------------------------------------------------------------
    // Segment computation (valid while in CALC: the read responses for
    // flowid_q arrive one cycle after the address is presented in RD_REQ)
    // ------------------------------------------------------------------
    assign calc_seq = rt_q ? rx_state_rd_resp_data.our_ack_state.ack_num
                           : tx_state_rd_resp_data.our_seq_num;

    tcp_tx_len_calc #(
        .MSS (MSS)
    ) u_len_calc (
        .seq       (calc_seq),
        .ackd      (rx_state_rd_resp_data.our_ack_state.ack_num),
        .tail      (tx_tail_ptr_rd_resp_data),
        .their_win (rx_state_rd_resp_data.their_win_size),
        .len       (calc_len),
        .avail     (calc_avail)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    // NOTE: state and datapath registers use <= so every flop samples the
    // pre-edge values of its neighbours, regardless of process order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        cmd_accept   = 1'b0;
        skip         = 1'b0;
        seg_fire     = 1'b0;
        sched_tx_rdy = 1'b0;
        seg_out_val  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // rst gates ready so it reads 0 while reset is asserted.
                sched_tx_rdy = rst;
                if (sched_tx_val && rst) begin
                    cmd_accept = 1'b1;
                    state_d    = ST_RD_REQ;
                end
            end
            ST_RD_REQ: begin
                state_d = ST_CALC;
            end
            ST_CALC: begin
                // Nothing to send and no ack owed: drop back to IDLE and
                // only report the service to the scheduler.
                if (calc_len == '0 && !ack_q) begin
                    skip    = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                seg_out_val = 1'b1;
                if (seg_out_rdy) begin
                    seg_fire = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Command and segment registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flowid_q     <= '0;
            rt_q         <= 1'b0;
            ack_q        <= 1'b0;
            calc_q       <= '0;
            their_ack_q  <= '0;
            our_win_q    <= '0;
            tuple_q      <= '0;
            tx_seq_q     <= '0;
            skip_pulse_q <= 1'b0;
        end else begin
            skip_pulse_q <= skip;
            if (cmd_accept) begin
                flowid_q <= sched_tx_flowid;
                rt_q     <= sched_tx_rt;
                ack_q    <= sched_tx_ack;
            end
            if (state_q == ST_CALC) begin
                calc_q.seq   <= calc_seq;
                calc_q.len   <= calc_len;
                calc_q.avail <= calc_avail;
                their_ack_q  <= rx_state_rd_resp_data.their_ack_num;
                our_win_q    <= rx_state_rd_resp_data.our_win_size;
                tuple_q      <= flow_tuple_rd_resp_data;
                tx_seq_q     <= tx_state_rd_resp_data.our_seq_num;
            end
        end
    end

    // ------------------------------------------------------------------
    // Header assembly
    // ------------------------------------------------------------------
    assign hdr_flags = TCP_FLAG_ACK | ((calc_q.len != '0) ? TCP_FLAG_PSH : 8'h00);

    tcp_hdr_assembler u_hdr_asm (
        .src_port (tuple_q.host_port),
        .dst_port (tuple_q.dest_port),
        .seq_num  (calc_q.seq),
        .ack_num  (their_ack_q),
        .flags    (hdr_flags),
        .win_size (our_win_q),
        .hdr      (hdr)
    );

    assign next_seq = seq_max_fwd(tx_seq_q, calc_q.seq + 32'(calc_q.len));

    // ------------------------------------------------------------------
    // Outputs; data fields are held at zero while their valid is low.
    // ------------------------------------------------------------------
    always_comb begin
        tx_state_rd_req_addr    = flowid_q;
        rx_state_rd_req_addr    = flowid_q;
        tx_tail_ptr_rd_req_addr = flowid_q;
        flow_tuple_rd_req_addr  = flowid_q;

        seg_out_hdr     = '0;
        seg_out_flowid  = '0;
        seg_out_src_ip  = '0;
        seg_out_dst_ip  = '0;
        seg_out_payload = '0;
        if (seg_out_val) begin
            seg_out_hdr                  = hdr;
            seg_out_flowid               = flowid_q;
            seg_out_src_ip               = tuple_q.host_ip;
            seg_out_dst_ip               = tuple_q.dest_ip;
            seg_out_payload.payload_addr = calc_q.seq[PTR_W-1:0];
            seg_out_payload.payload_len  = calc_q.len;
        end

        tx_state_wr_req_val  = seg_fire;
        tx_state_wr_req_addr = '0;
        tx_state_wr_req_data = '0;
        if (seg_fire) begin
            tx_state_wr_req_addr             = flowid_q;
            tx_state_wr_req_data.our_seq_num = next_seq;
        end

        sched_update_val = seg_fire | skip_pulse_q;
        sched_update_cmd = '0;
        if (sched_update_val) begin
            sched_update_cmd.flowid = flowid_q;
        end
        if (seg_fire) begin
            sched_update_cmd.ack_pend  = SCHED_CLEAR;
            sched_update_cmd.rt_pend   = rt_q ? SCHED_CLEAR : SCHED_NOP;
            // The buffer is drained only if this segment took every byte.
            sched_update_cmd.data_pend = (32'(calc_q.len) == 32'(calc_q.avail))
                                         ? SCHED_CLEAR : SCHED_NOP;
        end
    end

endmodule

// File: tb/tb_tcp_tx_seg_builder.sv
// Directed self-checking bench for tcp_tx_seg_builder.
// State memories are modelled as 1-cycle synchronous-read arrays.

module tb_tcp_tx_seg_builder;
    import tcp_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic                   sched_tx_val = 1'b0;
    logic                   sched_tx_rdy;
    logic [FLOWID_W-1:0]    sched_tx_flowid = '0;
    logic                   sched_tx_rt = 1'b0;
    logic                   sched_tx_ack = 1'b0;
    logic [FLOWID_W-1:0]    tx_rd_addr, rx_rd_addr, tail_rd_addr, tup_rd_addr;
    smol_tx_state_struct    tx_resp = '0;
    smol_rx_state_struct    rx_resp = '0;
    logic [PTR_W-1:0]       tail_resp = '0;
    four_tuple_struct       tup_resp = '0;
    logic                   wr_val;
    logic [FLOWID_W-1:0]    wr_addr;
    smol_tx_state_struct    wr_data;
    logic                   seg_out_val;
    logic                   seg_out_rdy = 1'b0;
    tcp_pkt_hdr             seg_out_hdr;
    logic [FLOWID_W-1:0]    seg_out_flowid;
    logic [IP_ADDR_W-1:0]   seg_out_src_ip, seg_out_dst_ip;
    payload_buf_struct      seg_out_payload;
    logic                   upd_val;
    sched_cmd_struct        upd_cmd;

    tcp_tx_seg_builder dut (
        .clk                      (clk),
        .rst                      (rst),
        .sched_tx_val             (sched_tx_val),
        .sched_tx_rdy             (sched_tx_rdy),
        .sched_tx_flowid          (sched_tx_flowid),
        .sched_tx_rt              (sched_tx_rt),
        .sched_tx_ack             (sched_tx_ack),
        .tx_state_rd_req_addr     (tx_rd_addr),
        .tx_state_rd_resp_data    (tx_resp),
        .rx_state_rd_req_addr     (rx_rd_addr),
        .rx_state_rd_resp_data    (rx_resp),
        .tx_tail_ptr_rd_req_addr  (tail_rd_addr),
        .tx_tail_ptr_rd_resp_data (tail_resp),
        .flow_tuple_rd_req_addr   (tup_rd_addr),
        .flow_tuple_rd_resp_data  (tup_resp),
        .tx_state_wr_req_val      (wr_val),
        .tx_state_wr_req_addr     (wr_addr),
        .tx_state_wr_req_data     (wr_data),
        .seg_out_val              (seg_out_val),
        .seg_out_rdy              (seg_out_rdy),
        .seg_out_hdr              (seg_out_hdr),
        .seg_out_flowid           (seg_out_flowid),
        .seg_out_src_ip           (seg_out_src_ip),
        .seg_out_dst_ip           (seg_out_dst_ip),
        .seg_out_payload          (seg_out_payload),
        .sched_update_val         (upd_val),
        .sched_update_cmd         (upd_cmd)
    );

    smol_tx_state_struct tx_mem   [64];
    smol_rx_state_struct rx_mem   [64];
    logic [PTR_W-1:0]    tail_mem [64];
    four_tuple_struct    tup_mem  [64];

    always @(posedge clk) begin
        tx_resp   <= tx_mem[tx_rd_addr];
        rx_resp   <= rx_mem[rx_rd_addr];
        tail_resp <= tail_mem[tail_rd_addr];
        tup_resp  <= tup_mem[tup_rd_addr];
    end

    int wr_cnt = 0;
    int upd_cnt = 0;
    always @(posedge clk) begin
        if (rst && wr_val)  wr_cnt++;
        if (rst && upd_val) upd_cnt++;
    end

    int n_cmp = 0;
    int n_bad = 0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic load_flow(input logic [FLOWID_W-1:0] f, input logic [31:0] our_seq,
                             input logic [31:0] ackd, input logic [15:0] twin,
                             input logic [PTR_W-1:0] tail);
        tx_mem[f].our_seq_num           = our_seq;
        rx_mem[f].our_ack_state.ack_num = ackd;
        rx_mem[f].their_win_size        = twin;
        rx_mem[f].their_ack_num         = 32'hA000_0000 + 32'(f);
        rx_mem[f].our_win_size          = 16'h2000 + 16'(f);
        tail_mem[f]                     = tail;
        tup_mem[f].host_ip              = 32'h0A00_0001;
        tup_mem[f].dest_ip              = 32'h0A00_0100 + 32'(f);
        tup_mem[f].host_port            = 16'h1234;
        tup_mem[f].dest_port            = 16'h5000 + 16'(f);
    endtask

    function automatic tcp_pkt_hdr mk_hdr(input logic [FLOWID_W-1:0] f,
                                          input logic [31:0] seq, input logic [7:0] flags);
        tcp_pkt_hdr h;
        h             = '0;
        h.src_port    = 16'h1234;
        h.dst_port    = 16'h5000 + 16'(f);
        h.seq_num     = seq;
        h.ack_num     = 32'hA000_0000 + 32'(f);
        h.data_offset = 4'd5;
        h.flags       = flags;
        h.win_size    = 16'h2000 + 16'(f);
        return h;
    endfunction

    // Presents a command in IDLE; returns at the negedge of RD_REQ.
    task automatic issue_cmd(input logic [FLOWID_W-1:0] f, input logic rt, input logic ack);
        @(negedge clk);
        sched_tx_val    = 1'b1;
        sched_tx_flowid = f;
        sched_tx_rt     = rt;
        sched_tx_ack    = ack;
        @(negedge clk);
        sched_tx_val = 1'b0;
        sched_tx_rt  = 1'b0;
        sched_tx_ack = 1'b0;
    endtask

    // Waits (bounded) for seg_out_val; cyc = negedges after RD_REQ, -1 on timeout.
    task automatic wait_seg(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (seg_out_val) begin
                cyc = i;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({sched_tx_rdy, seg_out_val, wr_val, upd_val} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_ctrl: got %b want 0000", {sched_tx_rdy, seg_out_val, wr_val, upd_val});
        end
        n_cmp++;
        if ({seg_out_hdr, seg_out_payload, tx_rd_addr, upd_cmd} !== '0) begin
            n_bad++; $display("FAIL reset_data: hdr %h payload %h addr %h upd %h want all 0", seg_out_hdr, seg_out_payload, tx_rd_addr, upd_cmd);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (sched_tx_rdy !== 1'b1) begin
            n_bad++; $display("FAIL reset_release_rdy: got %b want 1", sched_tx_rdy);
        end
    endtask

    task automatic test_basic();
        int cyc;
        int wr0;
        load_flow(6'd1, 32'h100, 32'h100, 16'h1000, 16'h0300);
        wr0 = wr_cnt;
        issue_cmd(6'd1, 1'b0, 1'b0);
        n_cmp++;
        if ({tx_rd_addr, rx_rd_addr, tail_rd_addr, tup_rd_addr, sched_tx_rdy} !== {{4{6'd1}}, 1'b0}) begin
            n_bad++; $display("FAIL basic_rd_addr: got %h %h %h %h rdy %b want 1 1 1 1 rdy 0", tx_rd_addr, rx_rd_addr, tail_rd_addr, tup_rd_addr, sched_tx_rdy);
        end
        wait_seg(cyc);
        n_cmp++;
        if (cyc != 2) begin
            n_bad++; $display("FAIL basic_latency: got %0d want 2", cyc);
        end
        n_cmp++;
        if (seg_out_hdr !== mk_hdr(6'd1, 32'h100, 8'h18)) begin
            n_bad++; $display("FAIL basic_hdr: got %h want %h", seg_out_hdr, mk_hdr(6'd1, 32'h100, 8'h18));
        end
        n_cmp++;
        if ({seg_out_src_ip, seg_out_dst_ip, seg_out_flowid} !== {32'h0A00_0001, 32'h0A00_0101, 6'd1}) begin
            n_bad++; $display("FAIL basic_ip_flow: got %h %h %h want 0a000001 0a000101 01", seg_out_src_ip, seg_out_dst_ip, seg_out_flowid);
        end
        n_cmp++;
        if (seg_out_payload !== {16'h0100, 16'h0200}) begin
            n_bad++; $display("FAIL basic_payload: got %h want 01000200", seg_out_payload);
        end
        n_cmp++;
        if ({wr_val, upd_val} !== 2'b00) begin
            n_bad++; $display("FAIL basic_no_early_wr: got %b want 00", {wr_val, upd_val});
        end
        seg_out_rdy = 1'b1;
        #1;
        n_cmp++;
        if ({wr_val, upd_val, wr_addr, wr_data} !== {2'b11, 6'd1, 32'h300}) begin
            n_bad++; $display("FAIL basic_wr: got val %b upd %b addr %h seq %h want 1 1 01 00000300", wr_val, upd_val, wr_addr, wr_data);
        end
        n_cmp++;
        if (upd_cmd !== '{flowid: 6'd1, rt_pend: SCHED_NOP, ack_pend: SCHED_CLEAR, data_pend: SCHED_CLEAR}) begin
            n_bad++; $display("FAIL basic_upd: got %h want flow 1 rt NOP ack CLEAR data CLEAR", upd_cmd);
        end
        @(negedge clk);
        seg_out_rdy = 1'b0;
        n_cmp++;
        if ({seg_out_val, wr_val, upd_val, sched_tx_rdy} !== 4'b0001 || wr_cnt - wr0 != 1) begin
            n_bad++; $display("FAIL basic_after: got val %b wr %b upd %b rdy %b writes %0d want 0 0 0 1 writes 1", seg_out_val, wr_val, upd_val, sched_tx_rdy, wr_cnt - wr0);
        end
    endtask

    task automatic test_mss();
        int cyc;
        load_flow(6'd2, 32'h1000, 32'h1000, 16'hFFFF, 16'h1BB8);
        issue_cmd(6'd2, 1'b0, 1'b0);
        wait_seg(cyc);
        n_cmp++;
        if (cyc != 2 || seg_out_payload !== {16'h1000, 16'd1460}) begin
            n_bad++; $display("FAIL mss_payload: got cyc %0d payload %h want cyc 2 payload %h", cyc, seg_out_payload, {16'h1000, 16'd1460});
        end
        seg_out_rdy = 1'b1;
        #1;
        n_cmp++;
        if (wr_data.our_seq_num !== 32'h15B4 || upd_cmd.data_pend !== SCHED_NOP) begin
            n_bad++; $display("FAIL mss_wr: got seq %h data_pend %0d want 000015b4 NOP", wr_data, upd_cmd.data_pend);
        end
        @(negedge clk);
        seg_out_rdy = 1'b0;
    endtask

    task automatic test_window();
        int cyc;
        int wr0;
        int upd0;
        bit seen;
        load_flow(6'd3, 32'h280, 32'h200, 16'h0100, 16'h0680);
        issue_cmd(6'd3, 1'b0, 1'b0);
        wait_seg(cyc);
        n_cmp++;
        if (cyc != 2 || seg_out_payload !== {16'h0280, 16'h0080}) begin
            n_bad++; $display("FAIL win_payload: got cyc %0d payload %h want cyc 2 payload 02800080", cyc, seg_out_payload);
        end
        seg_out_rdy = 1'b1;
        #1;
        n_cmp++;
        if (wr_data.our_seq_num !== 32'h300 || upd_cmd.data_pend !== SCHED_NOP) begin
            n_bad++; $display("FAIL win_wr: got seq %h data_pend %0d want 00000300 NOP", wr_data, upd_cmd.data_pend);
        end
        @(negedge clk);
        seg_out_rdy = 1'b0;
        // Window fully consumed by in-flight bytes and no ack owed.
        rx_mem[3].their_win_size = 16'h0080;
        wr0  = wr_cnt;
        upd0 = upd_cnt;
        issue_cmd(6'd3, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({upd_val, seg_out_val, wr_val, sched_tx_rdy} !== 4'b1001) begin
            n_bad++; $display("FAIL skip_pulse: got upd %b seg %b wr %b rdy %b want 1 0 0 1", upd_val, seg_out_val, wr_val, sched_tx_rdy);
        end
        n_cmp++;
        if (upd_cmd !== '{flowid: 6'd3, rt_pend: SCHED_NOP, ack_pend: SCHED_NOP, data_pend: SCHED_NOP}) begin
            n_bad++; $display("FAIL skip_upd: got %h want flow 3 all NOP", upd_cmd);
        end
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (seg_out_val) seen = 1'b1;
        end
        n_cmp++;
        if (seen || wr_cnt != wr0 || upd_cnt - upd0 != 1) begin
            n_bad++; $display("FAIL skip_quiet: got seg %b writes %0d updates %0d want 0 0 1", seen, wr_cnt - wr0, upd_cnt - upd0);
        end
    endtask

    task automatic test_retransmit();
        int cyc;
        load_flow(6'd4, 32'h500, 32'h100, 16'h1000, 16'h0500);
        issue_cmd(6'd4, 1'b1, 1'b0);
        wait_seg(cyc);
        n_cmp++;
        if (cyc != 2 || seg_out_hdr !== mk_hdr(6'd4, 32'h100, 8'h18) || seg_out_payload !== {16'h0100, 16'h0400}) begin
            n_bad++; $display("FAIL rt_seg: got cyc %0d hdr %h payload %h want 2 %h 01000400", cyc, seg_out_hdr, seg_out_payload, mk_hdr(6'd4, 32'h100, 8'h18));
        end
        seg_out_rdy = 1'b1;
        #1;
        n_cmp++;
        if (wr_data.our_seq_num !== 32'h500 || upd_cmd !== '{flowid: 6'd4, rt_pend: SCHED_CLEAR, ack_pend: SCHED_CLEAR, data_pend: SCHED_CLEAR}) begin
            n_bad++; $display("FAIL rt_wr: got seq %h upd %h want 00000500 flow 4 all CLEAR", wr_data, upd_cmd);
        end
        @(negedge clk);
        seg_out_rdy = 1'b0;
        // Partial retransmit: seq+len = 0x300 lies behind our_seq_num.
        tail_mem[4] = 16'h0300;
        issue_cmd(6'd4, 1'b1, 1'b0);
        wait_seg(cyc);
        n_cmp++;
        if (cyc != 2 || seg_out_payload !== {16'h0100, 16'h0200}) begin
            n_bad++; $display("FAIL rt_partial_seg: got cyc %0d payload %h want 2 01000200", cyc, seg_out_payload);
        end
        seg_out_rdy = 1'b1;
        #1;
        n_cmp++;
        if (wr_data.our_seq_num !== 32'h500) begin
            n_bad++; $display("FAIL rt_no_backwards: got %h want 00000500", wr_data);
        end
        @(negedge clk);
        seg_out_rdy = 1'b0;
    endtask

    task automatic test_ack_backpressure();
        int cyc;
        int wr0;
        load_flow(6'd5, 32'h700, 32'h700, 16'h1000, 16'h0700);
        wr0 = wr_cnt;
        issue_cmd(6'd5, 1'b0, 1'b1);
        wait_seg(cyc);
        n_cmp++;
        if (cyc != 2) begin
            n_bad++; $display("FAIL ack_latency: got %0d want 2", cyc);
        end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if ({seg_out_val, wr_val, upd_val, seg_out_hdr, seg_out_payload} !== {3'b100, mk_hdr(6'd5, 32'h700, 8'h10), 16'h0700, 16'h0000}) begin
                n_bad++; $display("FAIL ack_hold_%0d: got val %b wr %b upd %b hdr %h payload %h want 1 0 0 %h 07000000", i, seg_out_val, wr_val, upd_val, seg_out_hdr, seg_out_payload, mk_hdr(6'd5, 32'h700, 8'h10));
            end
            @(negedge clk);
        end
        seg_out_rdy = 1'b1;
        #1;
        n_cmp++;
        if ({wr_val, upd_val, wr_data} !== {2'b11, 32'h700} || upd_cmd !== '{flowid: 6'd5, rt_pend: SCHED_NOP, ack_pend: SCHED_CLEAR, data_pend: SCHED_CLEAR}) begin
            n_bad++; $display("FAIL ack_wr: got wr %b upd %b seq %h cmd %h want 1 1 00000700 flow 5 NOP/CLEAR/CLEAR", wr_val, upd_val, wr_data, upd_cmd);
        end
        @(negedge clk);
        seg_out_rdy = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (wr_cnt - wr0 != 1) begin
            n_bad++; $display("FAIL ack_single_pulse: got %0d writes want 1", wr_cnt - wr0);
        end
    endtask

    task automatic test_wrap_reset();
        int cyc;
        int wr0;
        load_flow(6'd6, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 16'h1000, 16'h0010);
        issue_cmd(6'd6, 1'b0, 1'b0);
        wait_seg(cyc);
        n_cmp++;
        if (cyc != 2 || seg_out_payload !== {16'hFFF0, 16'h0020} || seg_out_hdr.seq_num !== 32'hFFFF_FFF0) begin
            n_bad++; $display("FAIL wrap_seg: got cyc %0d payload %h seq %h want 2 fff00020 fffffff0", cyc, seg_out_payload, seg_out_hdr.seq_num);
        end
        seg_out_rdy = 1'b1;
        #1;
        n_cmp++;
        if (wr_data.our_seq_num !== 32'h0000_0010 || upd_cmd.data_pend !== SCHED_CLEAR) begin
            n_bad++; $display("FAIL wrap_wr: got seq %h data_pend %0d want 00000010 CLEAR", wr_data, upd_cmd.data_pend);
        end
        @(negedge clk);
        seg_out_rdy = 1'b0;
        // Reset while a segment is waiting in OUT.
        wr0 = wr_cnt;
        issue_cmd(6'd6, 1'b0, 1'b0);
        wait_seg(cyc);
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({seg_out_val, wr_val, upd_val, sched_tx_rdy} !== 4'b0000 || seg_out_hdr !== '0) begin
            n_bad++; $display("FAIL reset_mid_out: got val %b wr %b upd %b rdy %b hdr %h want 0 0 0 0 0", seg_out_val, wr_val, upd_val, sched_tx_rdy, seg_out_hdr);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (sched_tx_rdy !== 1'b1 || wr_cnt != wr0) begin
            n_bad++; $display("FAIL reset_recover: got rdy %b writes %0d want 1 0", sched_tx_rdy, wr_cnt - wr0);
        end
        // A fresh command after reset runs normally.
        issue_cmd(6'd1, 1'b0, 1'b0);
        wait_seg(cyc);
        n_cmp++;
        if (cyc != 2 || seg_out_payload !== {16'h0100, 16'h0200}) begin
            n_bad++; $display("FAIL post_reset_seg: got cyc %0d payload %h want 2 01000200", cyc, seg_out_payload);
        end
        seg_out_rdy = 1'b1;
        @(negedge clk);
        seg_out_rdy = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            tx_mem[i]   = '0;
            rx_mem[i]   = '0;
            tail_mem[i] = '0;
            tup_mem[i]  = '0;
        end
        test_reset();
        test_basic();
        test_mss();
        test_window();
        test_retransmit();
        test_ack_backpressure();
        test_wrap_reset();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tcp_tx_seg_builder.md
# tcp_tx_seg_builder

Transmit-side segment builder for the TCP engine; it pairs with the RX datapath. It accepts a per-flow service command from the scheduler and reads the flow's TX/RX state, TX tail pointer and four-tuple. From these it computes sequence number, ack number, window and payload length, then emits one outbound TCP header plus payload descriptor over a val/rdy interface. It writes back the advanced `our_seq_num` and issues a scheduler update that clears the serviced pend bits.

## Interface
Parameters:
- `MSS`, default 1460: maximum payload bytes per segment.

Ports:
- `clk` in 1: single clock domain.
- `rst` in 1: reset, asynchronous, active-low.
- `sched_tx_val` in 1, `sched_tx_rdy` out 1: service-command handshake.
- `sched_tx_flowid` in `FLOWID_W`: flow to service.
- `sched_tx_rt` in 1: retransmit request; transmit from the last acked byte.
- `sched_tx_ack` in 1: ack pending; emit even if payload is 0.
- `tx_state_rd_req_addr` out `FLOWID_W`; `tx_state_rd_resp_data` in `smol_tx_state_struct`.
- `rx_state_rd_req_addr` out `FLOWID_W`; `rx_state_rd_resp_data` in `smol_rx_state_struct`.
- `tx_tail_ptr_rd_req_addr` out `FLOWID_W`; `tx_tail_ptr_rd_resp_data` in `TX_PAYLOAD_PTR_W+1`.
- `flow_tuple_rd_req_addr` out `FLOWID_W`; `flow_tuple_rd_resp_data` in `four_tuple_struct`.
- `tx_state_wr_req_val` out 1, `tx_state_wr_req_addr` out `FLOWID_W`, `tx_state_wr_req_data` out `smol_tx_state_struct`.
- `seg_out_val` out 1, `seg_out_rdy` in 1: segment handshake.
- `seg_out_hdr` out `tcp_pkt_hdr`: outbound header.
- `seg_out_flowid` out `FLOWID_W`.
- `seg_out_src_ip` out `` `IP_ADDR_W ``, `seg_out_dst_ip` out `` `IP_ADDR_W ``.
- `seg_out_payload` out `payload_buf_struct`: `payload_addr` = TX buffer pointer, `payload_len` = bytes.
- `sched_update_val` out 1; `sched_update_cmd` out `sched_cmd_struct`.

## Operation
FSM states: IDLE → RD_REQ → CALC → OUT → IDLE.
- **IDLE:** `sched_tx_rdy`=1. On val&rdy, register flowid, rt and ack, then go to RD_REQ.
- **RD_REQ:** all four read addresses are driven from the registered flowid. Memories have 1-cycle synchronous read; responses are captured at the end of this state.
- **CALC:** registers the results of the following computations.
  - `ackd` = `rx.our_ack_state.ack_num`.
  - `seq` = rt ? `ackd` : `tx.our_seq_num`.
  - `inflight` = `seq` − `ackd` (32-bit modular).
  - `usable` = (`their_win_size` > `inflight`) ? `their_win_size` − `inflight` : 0.
  - `avail` = `tail` − `seq[TX_PAYLOAD_PTR_W:0]` (modular over `TX_PAYLOAD_PTR_W+1` bits).
  - `len` = min(`avail`, `usable`, `MSS`).
  - If `len`==0 and !ack: go to IDLE with no segment and no write. The scheduler update still pulses, with `data_pend`=NOP.
- **OUT:** `seg_out_val`=1; all `seg_out_*` are stable until `seg_out_rdy`.
  - Header: `src_port`=`host_port`, `dst_port`=`dest_port`, `seq_num`=`seq`, `ack_num`=`rx.their_ack_num`, `win_size`=`rx.our_win_size`, flags `ACK`|(`len`≠0 ? `PSH` : 0).
  - IPs: `src_ip`=`host_ip`, `dst_ip`=`dest_ip`.
  - Payload: `payload_addr`=`seq[TX_PAYLOAD_PTR_W:0]`.
  - In the handshake cycle:
    - `tx_state_wr_req_val`=1 with `our_seq_num` = max-forward(`tx.our_seq_num`, `seq`+`len`). A retransmit never moves `our_seq_num` backwards; the comparison is modular.
    - `sched_update_val`=1 with `flowid`.
    - `ack_pend` = CLEAR.
    - `rt_pend` = rt ? CLEAR : NOP.
    - `data_pend` = (`len`==`avail`) ? CLEAR : NOP.
  - Then go to IDLE.
- Only one command is in flight at a time; there is no pipelining across flows.

## Timing
- Reset values, all outputs 0: `sched_tx_rdy`, `seg_out_val`, `tx_state_wr_req_val`, `sched_update_val`, and all data/addr outputs. FSM resets to IDLE.
- **Latency:**
  - Command accepted at cycle 0.
  - Read addresses valid in cycle 1.
  - CALC in cycle 2.
  - `seg_out_val` rises in cycle 3.
- **Throughput:** 4 cycles per command at best.
- **Backpressure:** OUT holds indefinitely. `sched_tx_rdy`=0 outside IDLE.
- **Write and update pulses:** each is exactly one cycle, coincident with the `seg_out` handshake. For a skipped segment, the `sched_update_val` pulse comes in the cycle after CALC.
- **Reset mid-operation:**
  - Asynchronous return to IDLE; all outputs drop immediately.
  - No partial writeback.
- **Wrap-around:** seq and pointer arithmetic are modular; `avail` is correct when `tail` < pointer numerically.
- **Window:** `their_win_size` of 0 gives `len`=0.

## Structure
- `seg_calc_struct` (seq, len, avail) and the `MSS` default go in `tcp_pkg`.
- The pure-combinational length/window computation is a natural sub-module, `tcp_tx_len_calc`: inputs `seq`, `ackd`, `tail`, `their_win`; outputs `len`, `avail`.
- Header fields are packed in the top-level, using the existing `tcp_hdr_assembler`.

## Test plan
- **Basic send:**
  - Stimulus: `seq`=0x100, `ackd`=0x100, `tail`=0x300, `win`=0x1000, `MSS`=1460.
  - Response: `len`=0x200, `PSH`|`ACK`, write `our_seq_num`=0x300, `data_pend` CLEAR.
- **MSS cap:**
  - Stimulus: `avail`=3000, `win` large.
  - Response: `len`=1460, `data_pend` NOP, `our_seq_num` += 1460.
- **Window limit:**
  - Stimulus: `inflight`=0x80, `win`=0x100, `avail`=0x400.
  - Response: `len`=0x80.
  - With `win`=0x80 and ack=0: no segment, no write, update pulse only.
- **Retransmit:**
  - Stimulus: rt=1, `ackd`=0x100, `our_seq_num`=0x500, `tail`=0x500.
  - Response: `seq_num`=0x100, `len`=0x400, `our_seq_num` stays 0x500, `rt_pend` CLEAR.
- **Pure ACK and backpressure:**
  - Stimulus: `avail`=0, ack=1, `seg_out_rdy` held low for 5 cycles.
  - Response: `ACK`-only header with `len`=0 stays stable all 5 cycles; the single-cycle write pulses on the handshake.
- **Wrap and reset:**
  - Stimulus: `tail` wrapped below the pointer, e.g. ptr = 2^W − 0x10, `tail`=0x10.
  - Response: `len`=0x20.
  - Deassert `rst` in OUT: `seg_out_val` drops immediately and the FSM returns to IDLE.
